bus_slave_ctrl: RTL
===================

# bus_slave_ctrl

Single-master transaction controller for the system bus. It accepts one read or write request at a time and decodes the target slave from the top two address bits. It drives the one-hot slave enable and the 2-bit slave select that steers the 3-to-1 read-data mux, then waits for the selected slave's ready. It returns registered read data with a one-cycle done pulse, and an error flag on decode miss or timeout.

## Interface
- ADDR_W, 16, master address width; top 2 bits are the slave index, the lower ADDR_W-2 bits are the slave offset
- DATA_W, 32, data width
- TIMEOUT, 15, maximum ACCESS cycles allowed for slave ready; 0 disables the timeout
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- m_req  in  1  master request, sampled only in IDLE
- m_we  in  1  1 = write, 0 = read
- m_addr  in  ADDR_W  master address
- m_wdata  in  DATA_W  write data
- m_rdata  out  DATA_W  registered read data
- m_done  out  1  one-cycle completion pulse
- m_err  out  1  valid only with m_done; 1 = decode error or timeout
- busy  out  1  high in any state other than IDLE
- s_sel  out  2  slave index; drives the read-data mux select
- s_en  out  3  one-hot slave enable
- s_we  out  1  slave write strobe qualifier
- s_addr  out  ADDR_W-2  slave offset
- s_wdata  out  DATA_W  slave write data
- s_rdata0, s_rdata1, s_rdata2  in  DATA_W  slave read data
- s_ready  in  3  per-slave ready

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If m_req=1: latch m_we, m_addr and m_wdata, and decode idx = m_addr[ADDR_W-1:ADDR_W-2].
  - idx 0–2: load s_sel=idx, clear the timeout counter, go to ACCESS.
  - idx 3 (decode error): set err=1, go to RESP; s_sel is unchanged and no slave is touched.
- **ACCESS**
  - s_en[s_sel]=1. s_we, s_addr and s_wdata are driven from the latched request.
  - The counter increments each cycle.
  - If s_ready[s_sel]=1: on a read, m_rdata <= mux(s_sel) output; err=0; go to RESP.
  - Else, if TIMEOUT≠0 and the counter reaches TIMEOUT-1: err=1, m_rdata <= 0 on a read, go to RESP.
  - Ready arriving in the final allowed cycle counts as success (ready has priority over timeout).
- **RESP**
  - m_done=1 and m_err=err for exactly one cycle, then go to IDLE.
- Ready bits of non-selected slaves are ignored in all states.
- Writes never modify m_rdata.
- s_en, s_we, m_done and m_err are decoded from state (Moore).
- Outside ACCESS: s_en=0 and s_we=0; s_sel, s_addr and s_wdata hold their last values.

## Timing
- Reset values: state IDLE, m_rdata 0, m_done 0, m_err 0, busy 0, s_sel 2'b00, s_en 3'b000, s_we 0, s_addr 0, s_wdata 0, counter 0.
- Best-case latency, with m_req high in IDLE at cycle 0:
  - ACCESS in cycle 1.
  - If ready is high in cycle 1, m_done and the new m_rdata are visible in cycle 2.
- Decode-error latency: m_done and m_err in cycle 1.
- Back-to-back: a new request is sampled in the IDLE cycle after RESP, so throughput is at best one transaction per 3 cycles. A master holding m_req high past m_done issues a second transaction.
- Timeout: with no ready, m_done and m_err assert TIMEOUT+1 cycles after m_req is sampled.
- Reset mid-operation:
  - Next edge returns the FSM to IDLE.
  - s_en drops the same edge.
  - No m_done is issued for the aborted transaction.

## Structure
- Shared package bus_pkg:
  - NUM_SLAVES=3.
  - Slave index constants SLV0/SLV1/SLV2 and DEC_ERR=2'b11.
  - State enum IDLE/ACCESS/RESP.
- One sub-module, bus_rdata_mux3:
  - 3-to-1 DATA_W select on s_sel.
  - Index 3 defaults to input 0.
  - Its output feeds the m_rdata register.

## Test plan
- Read slave 1: m_addr=0x4010, s_rdata1=0xDEADBEEF, s_ready=3'b010 in the first ACCESS cycle -> s_en=3'b010, s_addr=0x0010, m_done 2 cycles after request, m_rdata=0xDEADBEEF, m_err=0.
- Write slave 2: m_addr=0x8004, m_wdata=0x12345678, ready after 3 ACCESS cycles -> s_en=3'b100 and s_we=1 for 3 cycles, s_wdata=0x12345678, m_done with m_err=0, m_rdata unchanged.
- Decode error: m_addr=0xC000 -> no s_en activity, m_done and m_err in the next cycle, s_sel unchanged.
- Timeout: TIMEOUT=15, slave 0 never ready -> s_en=3'b001 for 15 cycles, then m_done with m_err=1 and m_rdata=0. A second run with ready in the 15th cycle -> m_err=0.
- Wrong-slave ready: target slave 0, s_ready=3'b110 only -> no completion until the timeout fires.
- rst_n low during ACCESS on slave 1 -> next cycle all outputs at reset values, no m_done. After release, a request to slave 0 completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared slave indices and controller state encoding for the system bus
package bus_pkg;
  localparam int NUM_SLAVES = 3;
  localparam logic [1:0] SLV0    = 2'b00;
  localparam logic [1:0] SLV1    = 2'b01;
  localparam logic [1:0] SLV2    = 2'b10;
  localparam logic [1:0] DEC_ERR = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/bus_rdata_mux3.sv
// bus_rdata_mux3: 3-to-1 read-data select; the unused index 3 falls back to input 0
module bus_rdata_mux3
  import bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_d0,
  input  logic [DATA_W-1:0] i_d1,
  input  logic [DATA_W-1:0] i_d2,
  output logic [DATA_W-1:0] o_d
);
  assign o_d = (i_sel == SLV1) ? i_d1 : (i_sel == SLV2) ? i_d2 : i_d0;
endmodule

// File: rtl/bus_slave_ctrl.sv
// bus_slave_ctrl: single-master transaction controller with address decode, ready wait and timeout
module bus_slave_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_m_req,
  input  logic                  i_m_we,
  input  logic [ADDR_W-1:0]     i_m_addr,
  input  logic [DATA_W-1:0]     i_m_wdata,
  output logic [DATA_W-1:0]     o_m_rdata,
  output logic                  o_m_done,
  output logic                  o_m_err,
  output logic                  o_busy,
  output logic [1:0]            o_s_sel,
  output logic [NUM_SLAVES-1:0] o_s_en,
  output logic                  o_s_we,
  output logic [ADDR_W-3:0]     o_s_addr,
  output logic [DATA_W-1:0]     o_s_wdata,
  input  logic [DATA_W-1:0]     i_s_rdata0,
  input  logic [DATA_W-1:0]     i_s_rdata1,
  input  logic [DATA_W-1:0]     i_s_rdata2,
  input  logic [NUM_SLAVES-1:0] i_s_ready
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  state_t             r_state;
  logic [1:0]         r_sel;
  logic               r_we;
  logic               r_err;
  logic [ADDR_W-3:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         w_idx;
  logic [3:0]         w_rdy4;
  logic               w_ready;
  logic               w_tmo;
  logic [DATA_W-1:0]  w_mux;
  assign w_idx   = i_m_addr[ADDR_W-1 -: 2];
  assign w_rdy4  = {1'b0, i_s_ready};
  assign w_ready = w_rdy4[r_sel];
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  bus_rdata_mux3 #(.DATA_W(DATA_W)) u_mux (
    .i_sel (r_sel),
    .i_d0  (i_s_rdata0),
    .i_d1  (i_s_rdata1),
    .i_d2  (i_s_rdata2),
    .o_d   (w_mux)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_sel   <= SLV0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_m_req) begin
          r_we    <= i_m_we;
          r_addr  <= i_m_addr[ADDR_W-3:0];
          r_wdata <= i_m_wdata;
          r_cnt   <= '0;
          if (w_idx == DEC_ERR) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_sel   <= w_idx;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          // ready wins over a timeout landing in the same cycle
          if (w_ready) begin
            if (!r_we) r_rdata <= w_mux;
            r_err   <= 1'b0;
            r_state <= RESP;
          end else if (w_tmo) begin
            if (!r_we) r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_m_rdata = r_rdata;
  assign o_m_done  = (r_state == RESP);
  assign o_m_err   = (r_state == RESP) && r_err;
  assign o_busy    = (r_state != IDLE);
  assign o_s_sel   = r_sel;
  assign o_s_en    = (r_state == ACCESS) ? (NUM_SLAVES'(1) << r_sel) : '0;
  assign o_s_we    = (r_state == ACCESS) && r_we;
  assign o_s_addr  = r_addr;
  assign o_s_wdata = r_wdata;
endmodule
